// File: rtl/alu_slice_seq_pkg.sv
// Shared types and constants for the nibble-serial 74181 sequencer.
// ALU_SEQ_OVF_EN (when defined) adds a two's-complement overflow output.
package alu_slice_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Common function selects; xor/xnor reuse the sub/add codes in logic mode.
    localparam logic [3:0] S_ADD  = 4'b1001;
    localparam logic [3:0] S_SUB  = 4'b0110;
    localparam logic [3:0] S_XOR  = 4'b0110;
    localparam logic [3:0] S_XNOR = 4'b1001;

endpackage

// File: rtl/alu_slice_seq_slice.sv
// Combinational 4-bit 74181 slice, active-high data, active-low carries.
// ALU_SEQ_OVF_EN (when defined) exposes the carry into bit 3 as c3.
module alu_slice_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       ci_n,
    output logic [3:0] f,
`ifdef ALU_SEQ_OVF_EN
    output logic       c3,
`endif
    output logic       co_n
);

    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;

    // Per-bit 74181 operand terms: arithmetic result is x plus y plus carry,
    // logic result is the complement of x xor y.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign x[gi] = a[gi] | (b[gi] & s[0]) | (~b[gi] & s[1]);
            assign y[gi] = (a[gi] & ~b[gi] & s[2]) | (a[gi] & b[gi] & s[3]);
        end
    endgenerate

    assign sum  = {1'b0, x} + {1'b0, y} + {4'b0000, ~ci_n};
    assign f    = m ? ~(x ^ y) : sum[3:0];
    assign co_n = ~sum[4];

`ifdef ALU_SEQ_OVF_EN
    assign c3 = sum[3] ^ x[3] ^ y[3];
`endif

endmodule

// File: rtl/alu_slice_seq.sv
// Nibble-serial 74181 ALU: one 4-bit slice reused NIBBLES times per request.
// ALU_SEQ_OVF_EN (when defined) adds the ovf output.
module alu_slice_seq
    import alu_slice_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic [3:0]             s,
    input  logic                   m,
    input  logic                   ci_n,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   f,
    output logic                   co_n,
`ifdef ALU_SEQ_OVF_EN
    output logic                   ovf,
`endif
    output logic                   aeqb
);

    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t           state_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     f_reg;
    logic [3:0]       s_reg;
    logic             m_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_f;
    logic             slice_co_n;

    assign slice_a = a_reg[4*cnt_reg +: 4];
    assign slice_b = b_reg[4*cnt_reg +: 4];

`ifdef ALU_SEQ_OVF_EN
    logic slice_c3;
    logic ovf_reg;

    alu_slice_4b u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .s    (s_reg),
        .m    (m_reg),
        .ci_n (carry_reg),
        .f    (slice_f),
        .c3   (slice_c3),
        .co_n (slice_co_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && cnt_reg == LAST) begin
            // Active-high carry into the sign bit versus carry out of it.
            ovf_reg <= ~m_reg & (slice_c3 ^ ~slice_co_n);
        end
    end

    assign ovf = ovf_reg;
`else
    alu_slice_4b u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .s    (s_reg),
        .m    (m_reg),
        .ci_n (carry_reg),
        .f    (slice_f),
        .co_n (slice_co_n)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            f_reg         <= '0;
            s_reg         <= 4'b0000;
            m_reg         <= 1'b0;
            carry_reg     <= 1'b1;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        s_reg        <= s;
                        m_reg        <= m;
                        carry_reg    <= ci_n;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    f_reg[4*cnt_reg +: 4] <= slice_f;
                    carry_reg             <= slice_co_n;
                    if (cnt_reg == LAST) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign f         = f_reg;
    // Carry is meaningless in logic mode, so report "no carry" there.
    assign co_n      = m_reg | carry_reg;
    assign aeqb      = &f_reg;

endmodule

// File: tb/tb_alu_slice_seq.sv
// Self-checking bench for alu_slice_seq: directed table, random ops vs a
// function-table model, backpressure and mid-operation reset sequences.
module tb_alu_slice_seq;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   s = 4'b0000;
    logic         m = 1'b0;
    logic         ci_n = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] f;
    logic         co_n;
    logic         aeqb;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    alu_slice_seq #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .ci_n      (ci_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .co_n      (co_n),
`ifdef ALU_SEQ_OVF_EN
        .ovf       (ovf),
`endif
        .aeqb      (aeqb)
    );

`ifndef ALU_SEQ_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Whole-word 74181 datasheet table: logic functions directly, arithmetic
    // as "p plus q plus carry" with minus-one expressed as adding all ones.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic [3:0] ms, input logic mm, input logic mci_n,
                         output logic [W-1:0] mf, output logic mco_n, output logic movf);
        logic [W-1:0] p, q, ones;
        logic [W:0]   sum;
        logic [W-1:0] low;
        ones = '1;
        p = '0;
        q = '0;
        if (mm) begin
            case (ms)
                4'h0: mf = ~ma;
                4'h1: mf = ~(ma | mb);
                4'h2: mf = ~ma & mb;
                4'h3: mf = '0;
                4'h4: mf = ~(ma & mb);
                4'h5: mf = ~mb;
                4'h6: mf = ma ^ mb;
                4'h7: mf = ma & ~mb;
                4'h8: mf = ~ma | mb;
                4'h9: mf = ~(ma ^ mb);
                4'hA: mf = mb;
                4'hB: mf = ma & mb;
                4'hC: mf = ones;
                4'hD: mf = ma | ~mb;
                4'hE: mf = ma | mb;
                default: mf = ma;
            endcase
            mco_n = 1'b1;
            movf  = 1'b0;
        end else begin
            case (ms)
                4'h0: begin p = ma;        q = '0;        end
                4'h1: begin p = ma | mb;   q = '0;        end
                4'h2: begin p = ma | ~mb;  q = '0;        end
                4'h3: begin p = '0;        q = ones;      end
                4'h4: begin p = ma;        q = ma & ~mb;  end
                4'h5: begin p = ma | mb;   q = ma & ~mb;  end
                4'h6: begin p = ma;        q = ~mb;       end
                4'h7: begin p = ma & ~mb;  q = ones;      end
                4'h8: begin p = ma;        q = ma & mb;   end
                4'h9: begin p = ma;        q = mb;        end
                4'hA: begin p = ma | ~mb;  q = ma & mb;   end
                4'hB: begin p = ma & mb;   q = ones;      end
                4'hC: begin p = ma;        q = ma;        end
                4'hD: begin p = ma | mb;   q = ma;        end
                4'hE: begin p = ma | ~mb;  q = ma;        end
                default: begin p = ma;     q = ones;      end
            endcase
            sum   = {1'b0, p} + {1'b0, q} + {{W{1'b0}}, ~mci_n};
            low   = {1'b0, p[W-2:0]} + {1'b0, q[W-2:0]} + {{(W-1){1'b0}}, ~mci_n};
            mf    = sum[W-1:0];
            mco_n = ~sum[W];
            movf  = low[W-1] ^ sum[W];
        end
    endtask

    // One full request: accept, count edges to out_valid, capture, release.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [3:0] ts, input logic tm, input logic tci,
                         output logic [W-1:0] rf, output logic rco, output logic raeqb,
                         output logic rovf, output int lat);
        @(negedge clk);
        chk_bit("in_ready_idle", in_ready, 1'b1);
        a = ta; b = tb_; s = ts; m = tm; ci_n = tci;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~ta; b = ~tb_; s = ~ts; m = ~tm; ci_n = ~tci;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        rf    = f;
        rco   = co_n;
        raeqb = aeqb;
        rovf  = ovf;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("release_out_valid", out_valid, 1'b0);
        chk_bit("release_in_ready", in_ready, 1'b1);
        out_ready = 1'b0;
        $display("op a=%h b=%h s=%b m=%b ci_n=%b -> f=%h co_n=%b aeqb=%b ovf=%b lat=%0d",
                 ta, tb_, ts, tm, tci, rf, rco, raeqb, rovf, lat);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   s;
        logic         m;
        logic         ci_n;
        logic [W-1:0] ef;
        logic         eco_n;
        logic         eaeqb;
        logic         eovf;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [W-1:0] gf, mf, ra, rb, held_f;
        logic         gco, gaeqb, govf, mco, movf, rm, rci;
        logic [3:0]   rs;
        int           lat;

        vt[0] = '{16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1};
        vt[3] = '{16'h5000, 16'h0001, 4'b0110, 1'b0, 1'b0, 16'h4FFF, 1'b0, 1'b0, 1'b0};
        vt[4] = '{16'h5A5A, 16'h5A5A, 4'b1001, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
        vt[5] = '{16'h5A5A, 16'h0FF0, 4'b0110, 1'b1, 1'b0, 16'h55AA, 1'b1, 1'b0, 1'b0};
        vt[6] = '{16'h1234, 16'h5678, 4'b0011, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vt[7] = '{16'h00FF, 16'h1234, 4'b0000, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0};
        vt[8] = '{16'h0000, 16'h4321, 4'b1111, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
        vt[9] = '{16'h8000, 16'h0000, 4'b1100, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_word("rst_f", f, 16'h0000);
        chk_bit("rst_co_n", co_n, 1'b1);
        chk_bit("rst_aeqb", aeqb, 1'b0);
        chk_bit("rst_ovf", ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vt[i].a, vt[i].b, vt[i].s, vt[i].m, vt[i].ci_n, gf, gco, gaeqb, govf, lat);
            chk_int($sformatf("vec%0d_latency", i), lat, N);
            chk_word($sformatf("vec%0d_f", i), gf, vt[i].ef);
            chk_bit($sformatf("vec%0d_co_n", i), gco, vt[i].eco_n);
            chk_bit($sformatf("vec%0d_aeqb", i), gaeqb, vt[i].eaeqb);
`ifdef ALU_SEQ_OVF_EN
            chk_bit($sformatf("vec%0d_ovf", i), govf, vt[i].eovf);
`endif
        end

        for (int i = 0; i < 48; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rs  = 4'($urandom_range(0, 15));
            rm  = 1'($urandom_range(0, 1));
            rci = 1'($urandom_range(0, 1));
            model(ra, rb, rs, rm, rci, mf, mco, movf);
            do_op(ra, rb, rs, rm, rci, gf, gco, gaeqb, govf, lat);
            chk_int("rand_latency", lat, N);
            chk_word("rand_f", gf, mf);
            chk_bit("rand_co_n", gco, mco);
            chk_bit("rand_aeqb", gaeqb, &mf);
`ifdef ALU_SEQ_OVF_EN
            chk_bit("rand_ovf", govf, movf);
`endif
        end

        // Backpressure: result must hold while out_ready stays low.
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; s = 4'b1001; m = 1'b0; ci_n = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk_int("bp_latency", lat, N);
        held_f = f;
        chk_word("bp_f_initial", held_f, 16'h2233);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 16'hFFFF; b = 16'hFFFF; s = 4'b0000; m = 1'b1;
            @(posedge clk);
            #1;
            chk_word("bp_f_stable", f, held_f);
            chk_bit("bp_out_valid", out_valid, 1'b1);
            chk_bit("bp_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("bp_release_out_valid", out_valid, 1'b0);
        chk_bit("bp_release_in_ready", in_ready, 1'b1);
        chk_word("bp_f_after", f, 16'h2233);
        out_ready = 1'b0;
        $display("op backpressure a=1234 b=0fff held f=%h for 10 cycles", held_f);

        // Reset after two nibbles: operation abandoned, outputs back to reset.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; s = 4'b1001; m = 1'b0; ci_n = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_bit("midrst_out_valid", out_valid, 1'b0);
        chk_bit("midrst_in_ready", in_ready, 1'b1);
        chk_word("midrst_f", f, 16'h0000);
        chk_bit("midrst_co_n", co_n, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk_bit("midrst_no_result", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("op reset mid-run a=1111 b=2222 abandoned");
        do_op(16'hABCD, 16'h1111, 4'b1001, 1'b0, 1'b1, gf, gco, gaeqb, govf, lat);
        chk_int("postrst_latency", lat, N);
        chk_word("postrst_f", gf, 16'hBCDE);
        chk_bit("postrst_co_n", gco, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_slice_seq.md
ALU_SLICE_SEQ -- requirements
Module: alu_slice_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, slice count per operation (1..8); data width W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid & in_ready at a clk edge.
REQ-006 SHALL have port a, b  input  W each  operands.
REQ-007 SHALL have port s  input  4  74181 function select.
REQ-008 SHALL have port m  input  1  1 = logic mode, 0 = arithmetic mode.
REQ-009 SHALL have port ci_n  input  1  active-low carry into nibble 0.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port f  output  W  result.
REQ-013 SHALL have port co_n  output  1  active-low carry out of top nibble.
REQ-014 SHALL have port aeqb  output  1  high when f is all ones.

Function
REQ-015 States SHALL be IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-016 Handshake in IDLE SHALL register a, b, s, m, ci_n, clear the nibble counter, load the carry register with ci_n, and enter RUN; inputs changing afterwards SHALL be ignored.
REQ-017 Each RUN cycle SHALL drive one 4-bit slice with nibble k, the registered s/m, and the carry register; it SHALL write the slice F into f[4k+3:4k] and its carry-out into the carry register, then increment k.
REQ-018 After processing nibble NIBBLES-1, state SHALL go to DONE; out_valid SHALL rise exactly NIBBLES edges after the accepting edge.
REQ-019 Slice SHALL implement the full 74181 active-high-data function table: all 16 s codes, m=1 logic with carry ignored, m=0 arithmetic with ripple carry.
REQ-020 In DONE, f, co_n, aeqb, out_valid SHALL hold stable until out_valid & out_ready; on that edge state SHALL return to IDLE and out_valid SHALL fall.
REQ-021 co_n SHALL equal the carry register after the last nibble when m=0, and SHALL read 1 when m=1.
REQ-022 aeqb SHALL be combinational on the registered f, valid only when out_valid = 1.
REQ-023 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE; there are no back-to-back accepts from DONE.

Reset
REQ-024 rst_n low SHALL force state IDLE immediately, including mid-RUN, and abandon the operation without a result.
REQ-025 Reset values SHALL be: in_ready 1 (after reset release), out_valid 0, f 0, co_n 1, aeqb 0, carry register 1, counter 0, ovf 0 when present.

Configuration
REQ-026 With ALU_SEQ_OVF_EN defined, the module SHALL have output ovf (1 bit): two's-complement overflow = carry into bit W-1 XOR carry out of bit W-1 (active-high sense), for m=0 only, else 0, valid with out_valid.
REQ-027 Without ALU_SEQ_OVF_EN, the ovf port and the slice's bit-3 carry tap SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold the state enumeration type and named 4-bit s constants for add (1001), subtract (0110), xor (0110 logic) and xnor (1001 logic).
REQ-029 The 4-bit 74181 slice SHALL be a sub-module alu_slice_4b (inputs a, b, s, m, ci_n; outputs f, co_n, and c3 for overflow), purely combinational; the sequencer holds all state.

Verification
REQ-030 Add: a=0x1234, b=0x0FFF, s=1001, m=0, ci_n=1 -> f=0x2233, co_n=1, out_valid exactly 4 edges after accept.
REQ-031 Carry wrap: a=0xFFFF, b=0x0001, s=1001, m=0, ci_n=1 -> f=0x0000, co_n=0; with ALU_SEQ_OVF_EN ovf=0; a=0x7FFF, b=0x0001 -> f=0x8000, ovf=1.
REQ-032 Subtract: a=0x5000, b=0x0001, s=0110, m=0, ci_n=0 -> f=0x4FFF, co_n=0.
REQ-033 Logic xnor: a=b=0x5A5A, s=1001, m=1 -> f=0xFFFF, aeqb=1, co_n=1.
REQ-034 Backpressure: out_ready low 10 cycles in DONE -> f/out_valid stable, in_ready 0, new in_valid ignored; out_ready high -> IDLE next edge.
REQ-035 Reset mid-RUN after 2 nibbles -> state IDLE, out_valid 0, f 0; next request completes correctly.
